adder_bist: RTL and testbench

ADDER_BIST -- requirements
Module: adder_bist

---
 rtl/adder_bist_pkg.sv | 17 +
 rtl/adder_bist_ref.sv | 13 +
 rtl/adder_bist.sv | 150 +++++++++++++++
 tb/tb_adder_bist.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and defaults for the adder BIST controller.
// Optional feature macro: ADDER_BIST_STOP_ON_FAIL_EN (see adder_bist.sv).
package adder_bist_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 1;
    localparam int SETTLE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/adder_bist_ref.sv
// Golden adder: expected {cout,s} for the vector currently driven to the adder under test.
module adder_bist_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_bist.sv
// Exhaustive BIST sweep for a WIDTH-bit adder: drives every {cin,a,b}, counts mismatches.
// Optional: define ADDER_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               cin_o,
    input  logic [WIDTH-1:0]   s_i,
    input  logic               cout_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_cnt,
    output logic               fail_valid,
    output logic [2*WIDTH:0]   fail_vec,
    output state_e             dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
    // busy is high for the whole sweep and done stays high until the next
    // accepted start or reset, with pass/err_cnt/fail_* stable while done.

    localparam int VW = 2 * WIDTH + 1;
    localparam int EW = 2 * WIDTH + 2;
    localparam bit HAS_WAIT = (SETTLE > 0);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_e              state;
    state_e              state_nxt;
    logic [VW-1:0]       vec;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [EW-1:0]       err_q;
    logic                fvalid_q;
    logic [VW-1:0]       fvec_q;
    logic [WIDTH:0]      expected;
    logic                mismatch;
    logic                sweep_clr;
    logic                settle_load;
    logic                vec_inc;

    adder_bist_ref #(.WIDTH(WIDTH)) u_ref (
        .a   (vec[2*WIDTH-1:WIDTH]),
        .b   (vec[WIDTH-1:0]),
        .cin (vec[VW-1]),
        .sum (expected)
    );

    assign mismatch = (state == ST_COMPARE) && ({cout_i, s_i} != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sweep_clr   = 1'b0;
        settle_load = 1'b0;
        vec_inc     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sweep_clr = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                settle_load = 1'b1;
                state_nxt   = HAS_WAIT ? ST_WAIT : ST_COMPARE;
            end
            ST_WAIT: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (STOP_ON_FAIL && mismatch) begin
                    state_nxt = ST_DONE;
                end else if (&vec) begin
                    state_nxt = ST_DONE;
                end else begin
                    vec_inc   = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Only the first mismatch of a sweep is captured; later ones just count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_q      <= '0;
            fvalid_q   <= 1'b0;
            fvec_q     <= '0;
        end else begin
            if (sweep_clr) begin
                vec      <= '0;
                err_q    <= '0;
                fvalid_q <= 1'b0;
                fvec_q   <= '0;
            end else begin
                if (vec_inc) begin
                    vec <= vec + VW'(1);
                end
                if (mismatch) begin
                    err_q <= err_q + EW'(1);
                    if (!fvalid_q) begin
                        fvalid_q <= 1'b1;
                        fvec_q   <= vec;
                    end
                end
            end
            if (settle_load) begin
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == ST_WAIT) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end
    end

    assign {cin_o, a_o, b_o} = vec;
    assign busy       = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_COMPARE);
    assign done       = (state == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_cnt    = err_q;
    assign fail_valid = fvalid_q;
    assign fail_vec   = fvec_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench for adder_bist: a faultable behavioural adder, a sweep-level model and a done monitor.
module tb_adder_bist;
    import adder_bist_pkg::*;

    localparam int W  = 4;
    localparam int ST = 1;
    localparam int VW = 2 * W + 1;
    localparam int EW = 2 * W + 2;
    localparam int NV = 1 << VW;
    localparam int CW = 16;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] cycles;
        logic [VW-1:0] last_vec;
        logic [EW-1:0] errs;
        logic          pass;
        logic          fvalid;
        logic [VW-1:0] fvec;
    } exp_t;
    localparam int XW = $bits(exp_t);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_o, b_o, s_i;
    logic          cin_o, cout_i;
    logic          busy, done, pass, fail_valid;
    logic [EW-1:0] err_cnt;
    logic [VW-1:0] fail_vec;
    state_e        dbg_state;

    logic [XW-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            done_seen = 0;
    int            busy_cycles = 0;
    logic          done_q = 1'b0;
    logic          busy_q = 1'b0;

    // fault kinds: 0 none, 1 output bit stuck at value, 2 one vector corrupted by a mask
    int            fault_kind = 0;
    int            fault_bit = 0;
    logic          fault_val = 1'b0;
    logic [VW-1:0] fault_vec = '0;
    logic [W:0]    fault_mask = '0;
    int            cfg_gen = 0;

    adder_bist #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a_o), .b_o(b_o), .cin_o(cin_o),
        .s_i(s_i), .cout_i(cout_i),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] faulty_sum(input logic [VW-1:0] v);
        logic [W:0]   r;
        logic [W-1:0] a, b;
        logic         c;
        {c, a, b} = v;
        r = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
        case (fault_kind)
            1: r[fault_bit] = fault_val;
            2: if (v == fault_vec) r = r ^ fault_mask;
            default: ;
        endcase
        return r;
    endfunction

    always @(a_o, b_o, cin_o, cfg_gen) {cout_i, s_i} = faulty_sum({cin_o, a_o, b_o});

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_fault(input int kind, input int bitn, input logic val,
                             input logic [VW-1:0] v, input logic [W:0] mask);
        fault_kind = kind;
        fault_bit  = bitn;
        fault_val  = val;
        fault_vec  = v;
        fault_mask = mask;
        cfg_gen++;
    endtask

    // Sweep-level expectation from plain arithmetic over every {cin,a,b}.
    task automatic push_expected();
        int            errs;
        int            last;
        int            good;
        bit            have;
        logic [VW-1:0] first;
        logic [W-1:0]  a, b;
        logic          c;
        exp_t          e;
        errs = 0; have = 0; first = '0; last = NV - 1;
        for (int v = 0; v < NV; v++) begin
            {c, a, b} = VW'(v);
            good = int'(a) + int'(b) + int'(c);
            if (int'(faulty_sum(VW'(v))) != good) begin
                errs++;
                if (!have) begin
                    have = 1;
                    first = VW'(v);
                end
                if (STOP) begin
                    last = v;
                    break;
                end
            end
        end
        e.cycles   = CW'((last + 1) * (ST + 2));
        e.last_vec = VW'(last);
        e.errs     = EW'(errs);
        e.pass     = (errs == 0);
        e.fvalid   = have;
        e.fvec     = first;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per rising done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cycles = 0;
                done_q = 1'b0;
                busy_q = 1'b0;
            end else begin
                if (busy) busy_cycles = busy_q ? busy_cycles + 1 : 1;
                if (done && !done_q) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_t'(exp_q.pop_front());
                        check("sweep_cycles", busy_cycles, e.cycles);
                        check("err_cnt", err_cnt, e.errs);
                        check("pass", pass, e.pass);
                        check("fail_valid", fail_valid, e.fvalid);
                        check("fail_vec", fail_vec, e.fvec);
                        check("hold_vec", {cin_o, a_o, b_o}, e.last_vec);
                        check("busy_in_done", busy, 0);
                    end
                    done_seen++;
                end
                done_q = done;
                busy_q = busy;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_fail_valid"}, fail_valid, 0);
        check({tag, "_fail_vec"}, fail_vec, 0);
        check({tag, "_operands"}, {cin_o, a_o, b_o}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err_cnt, 0);
        check("start_fvalid_clr", fail_valid, 0);
    endtask

    task automatic run_sweep(input bit extra_starts);
        int n;
        n = done_seen;
        push_expected();
        pulse_start();
        if (extra_starts) begin
            repeat (8) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (489) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        for (int i = 0; i < 4000 && done_seen == n; i++) @(negedge clk);
        if (done_seen == n) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
            do_reset();
        end else begin
            repeat (3) @(negedge clk);
            check("done_hold", done, 1);
        end
    endtask

    initial begin
        int k;
        do_reset();
        check_reset_outputs("reset");
        repeat ($urandom_range(5, 20)) @(negedge clk);
        check_reset_outputs("idle");

        set_fault(0, 0, 1'b0, '0, '0);
        run_sweep(1'b0);
        set_fault(1, W, 1'b0, '0, '0);
        run_sweep(1'b0);
        set_fault(1, 0, 1'b1, '0, '0);
        run_sweep(1'b0);
        set_fault(0, 0, 1'b0, '0, '0);
        run_sweep(1'b1);

        // abort a sweep with reset, then a clean sweep must still pass
        push_expected();
        pulse_start();
        repeat (98) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_sweep(1'b0);

        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 2);
            set_fault(k, $urandom_range(0, W), 1'($urandom_range(0, 1)),
                      VW'($urandom_range(0, NV - 1)),
                      (W+1)'($urandom_range(1, (1 << (W + 1)) - 1)));
            run_sweep(k == 0 && $urandom_range(0, 1) == 1);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
